// File: rtl/fifo_feed_scheduler.sv
// Pops per-row FWFT FIFOs in a diagonal wavefront, skewing each row by one
// cycle so a systolic array sees row r start r cycles after row 0.
module fifo_feed_scheduler #(
    parameter int ROWS      = 4,
    parameter int WIDTH     = 16,
    parameter int LEN_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [ROWS-1:0]       empty,
    input  logic [ROWS*WIDTH-1:0] from_fifo,
    output logic [ROWS-1:0]       r_en,
    output logic [ROWS*WIDTH-1:0] to_array,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  done
);

    // Wide enough to reach len_q + ROWS - 1 without wrapping.
    localparam int CW = LEN_WIDTH + $clog2(ROWS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [LEN_WIDTH-1:0]  len_q, len_next;
    logic [ROWS*WIDTH-1:0] to_array_next;
    logic [ROWS-1:0]       active;
    logic                  stall;
    logic                  advance;
    logic                  last;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            active[r] = (cnt >= CW'(r)) && (cnt < CW'(r) + CW'(len_q));
        end
    end

    // A single starved active row freezes the whole wavefront so the skew between rows is kept.
    assign stall   = (state == FEED) && |(active & empty);
    assign advance = (state == FEED) && !stall && !abort;
    assign last    = (cnt == CW'(len_q) + CW'(ROWS - 2));

    assign r_en = advance ? active : '0;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        len_next   = len_q;
        case (state)
            IDLE: begin
                if (start && !abort && (len != '0)) begin
                    state_next = FEED;
                    cnt_next   = '0;
                    len_next   = len;
                end
            end
            FEED: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (advance) begin
                    cnt_next = cnt + CW'(1);
                    if (last) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        to_array_next = '0;
        if (advance) begin
            for (int r = 0; r < ROWS; r++) begin
                if (active[r]) to_array_next[r*WIDTH +: WIDTH] = from_fifo[r*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            to_array  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            len_q     <= len_next;
            to_array  <= to_array_next;
            valid_out <= advance;
        end
    end

endmodule

// File: tb/tb_fifo_feed_scheduler.sv
// Directed scenarios plus randomized traffic for fifo_feed_scheduler, checked
// cycle by cycle against a wavefront model built from the job rules.
module tb_fifo_feed_scheduler;

    localparam int ROWS = 4;
    localparam int WIDTH = 16;
    localparam int LW = 8;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [LW-1:0]         len = '0;
    logic [ROWS-1:0]       empty = '0;
    logic [ROWS*WIDTH-1:0] from_fifo = '0;
    logic [ROWS-1:0]       r_en;
    logic [ROWS*WIDTH-1:0] to_array;
    logic                  valid_out;
    logic                  busy;
    logic                  done;

    fifo_feed_scheduler #(.ROWS(ROWS), .WIDTH(WIDTH), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .len(len),
        .empty(empty), .from_fifo(from_fifo), .r_en(r_en), .to_array(to_array),
        .valid_out(valid_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Job model: job_on / job_done_phase describe the job; k counts wavefront advances.
    bit                    job_on = 0;
    bit                    done_phase = 0;
    int                    k = 0;
    int                    job_len = 0;
    logic [ROWS*WIDTH-1:0] exp_to = '0;
    bit                    exp_valid = 0;

    int last_done = -1;
    int n_busy = 0, n_ren0 = 0, n_ren3 = 0, n_done = 0;

    task automatic model_reset();
        job_on = 0; done_phase = 0; k = 0; job_len = 0; exp_to = '0; exp_valid = 0;
    endtask

    task automatic step(input logic s, input logic a, input logic [LW-1:0] l, input logic [ROWS-1:0] e);
        logic [ROWS-1:0]       act;
        logic [ROWS-1:0]       exp_ren;
        logic [ROWS*WIDTH-1:0] nxt;
        bit                    starved, adv;
        @(negedge clk);
        start = s; abort = a; len = l; empty = e;
        from_fifo = {$urandom, $urandom};
        #1;
        for (int r = 0; r < ROWS; r++) act[r] = job_on && (r <= k) && (k < r + job_len);
        starved = (act & e) != '0;
        adv     = job_on && !a && !starved;
        exp_ren = adv ? act : '0;

        check("r_en", 64'(r_en), 64'(exp_ren));
        check("to_array", to_array, exp_to);
        check("valid_out", 64'(valid_out), 64'(exp_valid));
        check("busy", 64'(busy), 64'(job_on || done_phase));
        check("done", 64'(done), 64'(done_phase));
        if (done === 1'b1) begin last_done = cyc; n_done++; end
        if (busy === 1'b1) n_busy++;
        if (r_en[0] === 1'b1) n_ren0++;
        if (r_en[3] === 1'b1) n_ren3++;

        nxt = '0;
        for (int r = 0; r < ROWS; r++) if (adv && act[r]) nxt[r*WIDTH +: WIDTH] = from_fifo[r*WIDTH +: WIDTH];
        exp_to = nxt;
        exp_valid = adv;
        if (done_phase) begin
            done_phase = 0;
        end else if (job_on) begin
            if (a) job_on = 0;
            else if (adv) begin
                k++;
                // Job ends once len + ROWS - 1 advances have happened.
                if (k == job_len + ROWS - 1) begin job_on = 0; done_phase = 1; end
            end
        end else if (s && !a && l != 0) begin
            job_on = 1; k = 0; job_len = int'(l);
        end
    endtask

    task automatic clear_counts();
        last_done = -1; n_busy = 0; n_ren0 = 0; n_ren3 = 0; n_done = 0;
    endtask

    task automatic run_out(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step(0, 0, 0, '0);
            if (!job_on && !done_phase) break;
        end
        check("job_timeout", 64'(i < budget), 64'(1));
    endtask

    int t0;

    initial begin
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(valid_out), 64'(0));
        check("rst_to_array", to_array, 64'(0));
        check("rst_r_en", 64'(r_en), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        @(negedge clk); rstn = 1'b1;

        // Basic job, FIFOs never empty.
        clear_counts();
        step(1, 0, 3, '0); t0 = cyc;
        run_out(30);
        step(0, 0, 0, '0);
        check("basic_done_t", 64'(last_done - t0), 64'(7));
        check("basic_busy_n", 64'(n_busy), 64'(7));
        check("basic_ren0_n", 64'(n_ren0), 64'(3));
        check("basic_ren3_n", 64'(n_ren3), 64'(3));

        // Row 1 starves for one cycle at T+2.
        clear_counts();
        step(1, 0, 3, '0); t0 = cyc;
        step(0, 0, 0, '0);
        step(0, 0, 0, 4'b0010);
        run_out(30);
        check("stall_done_t", 64'(last_done - t0), 64'(8));

        // Zero-length start is ignored.
        clear_counts();
        step(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
        check("len0_busy_n", 64'(n_busy + n_ren0 + n_done), 64'(0));

        // Abort at T+3, then a fresh job at T+5.
        clear_counts();
        step(1, 0, 5, '0); t0 = cyc;
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        step(0, 1, 0, '0);
        step(1, 1, 4, '0);
        check("abort_idle", 64'(busy), 64'(0));
        check("abort_no_done", 64'(n_done), 64'(0));
        step(1, 0, 5, '0); t0 = cyc;
        run_out(30);
        check("abort_rerun_done_t", 64'(last_done - t0), 64'(9));

        // Asynchronous reset mid-FEED.
        step(1, 0, 4, '0);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        #2 rstn = 1'b0;
        #1;
        check("async_valid", 64'(valid_out), 64'(0));
        check("async_to_array", to_array, 64'(0));
        check("async_busy", 64'(busy), 64'(0));
        check("async_r_en", 64'(r_en), 64'(0));
        model_reset();
        @(negedge clk); rstn = 1'b1;
        clear_counts();
        step(1, 0, 2, '0); t0 = cyc;
        run_out(30);
        check("post_rst_done_t", 64'(last_done - t0), 64'(6));

        // start pulsed during FEED is ignored.
        clear_counts();
        step(1, 0, 3, '0); t0 = cyc;
        step(0, 0, 0, '0);
        step(1, 0, 7, '0);
        run_out(30);
        check("restart_ign_done_t", 64'(last_done - t0), 64'(7));
        check("restart_ign_ndone", 64'(n_done), 64'(1));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [ROWS-1:0] e;
            for (int r = 0; r < ROWS; r++) e[r] = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                 LW'($urandom_range(0, 6)), e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
